// File: rtl/word_mask_accum.sv
`default_nettype none
// ============================================================================
// Module   : word_mask_accum
// Purpose  : Registered word-index decoder with an optional running OR-mask.
//            Emits either the one-hot bit of each accepted word or the
//            accumulated mask of all words since the last clear. It also
//            reports duplicates, out-of-range words, popcount and full.
// Revision : 1.0 - initial release
// ============================================================================
module word_mask_accum #(
  parameter int WORD_W = 4,
  parameter int N_BITS = 16,
  parameter int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              mode_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              clear_i,
  output logic [N_BITS-1:0] bits_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              dup_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  logic [N_BITS-1:0] onehot;
  logic              word_err;
  logic              accept;
  logic [N_BITS-1:0] acc_base;
  logic [N_BITS-1:0] acc_next;

  logic [N_BITS-1:0] acc_q,   acc_d;
  logic [N_BITS-1:0] bits_q,  bits_d;
  logic              valid_q, valid_d;
  logic              dup_q,   dup_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q,  full_d;

  // Out-of-range detection only exists when the index space exceeds N_BITS.
  if (N_BITS < (2 ** WORD_W)) begin : g_err_range
    assign word_err = (word_i >= WORD_W'(N_BITS));
  end else begin : g_err_none
    assign word_err = 1'b0;
  end

  // One-hot decode of the incoming word; all zero when out of range.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_BITS; i++) begin
      onehot[i] = (int'(word_i) == i);
    end
  end

  // Single output register: a new beat may enter when it is empty or draining.
  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  // Clear takes effect before the accepted word is merged into the mask.
  assign acc_base = clear_i ? '0 : acc_q;
  assign acc_next = acc_base | onehot;

  // Next-state for the output beat and the accumulator.
  always_comb begin
    acc_d   = clear_i ? '0 : acc_q;
    bits_d  = bits_q;
    valid_d = valid_q;
    dup_d   = dup_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      err_d   = word_err;
      if (mode_i) begin
        bits_d = acc_next;
        // onehot is zero for an out-of-range word, so dup is zero there too.
        dup_d  = |(acc_base & onehot);
        acc_d  = acc_next;
      end else begin
        bits_d = onehot;
        dup_d  = 1'b0;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Popcount and full track the accumulator value being written this cycle.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < N_BITS; i++) begin
      count_d = count_d + CNT_W'(acc_d[i]);
    end
    full_d = (count_d == CNT_W'(N_BITS));
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      acc_q   <= '0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      dup_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      bits_q  <= bits_d;
      valid_q <= valid_d;
      dup_q   <= dup_d;
      err_q   <= err_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign bits_o  = bits_q;
  assign valid_o = valid_q;
  assign dup_o   = dup_q;
  assign err_o   = err_q;
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule
`default_nettype wire

// File: doc/word_mask_accum.md
Name: word_mask_accum

Overview:
Parametrised, registered successor to the combinational word-to-one-hot decoder. Accepts a stream of word indices over a valid/ready handshake and emits either the one-hot bit for each word (decode mode) or a running OR-mask of all words seen since the last clear (accumulate mode). It also reports duplicates, out-of-range words, population count and full. It sits between the word-index generator and the skein input-bit assembly, and tracks which message words have been used.

Parameters:
WORD_W, 4, width of the input word index
N_BITS, 16, number of valid output bits; legal range 1..2**WORD_W
CNT_W, $clog2(N_BITS+1), width of the population count output

Ports:
clk_i  input  1  clock; all logic on the rising edge
rst_n_i  input  1  reset; synchronous, active-low
word_i  input  WORD_W  word index to decode
mode_i  input  1  0 = decode, 1 = accumulate; sampled on accept
valid_i  input  1  word_i/mode_i valid
ready_o  output  1  block can accept this cycle
clear_i  input  1  synchronous clear of the accumulator
bits_o  output  N_BITS  registered one-hot or mask result
valid_o  output  1  bits_o/dup_o/err_o valid
ready_i  input  1  downstream accepts the output
dup_o  output  1  accepted word's bit was already set in the accumulator (accumulate mode only)
err_o  output  1  accepted word >= N_BITS
count_o  output  CNT_W  popcount of the accumulator
full_o  output  1  accumulator has all N_BITS set

Behaviour:
- Reset (rst_n_i=0 at a clock edge): bits_o=0, valid_o=0, dup_o=0, err_o=0, count_o=0, full_o=0, accumulator=0. Reset overrides clear_i and any accept.
- ready_o = !valid_o || ready_i. This is combinational and gives a single output register with pass-through backpressure.
- Accept = valid_i && ready_o. Latency is 1 cycle from accept to valid_o=1.
- Without a new accept: if valid_o && ready_i, valid_o goes to 0 next cycle. If valid_o && !ready_i, bits_o, dup_o and err_o hold stable.
- onehot = (word_i < N_BITS) ? 1<<word_i : 0. err = (word_i >= N_BITS).
- Decode mode on accept:
  - bits_o <= onehot; err_o <= err; dup_o <= 0.
  - Accumulator, count_o and full_o are unchanged.
- Accumulate mode on accept:
  - acc_base = clear_i ? 0 : acc.
  - acc_next = acc_base | onehot.
  - bits_o <= acc_next; dup_o <= acc_base[word_i] (0 when err); err_o <= err.
  - acc <= acc_next.
- An out-of-range word in accumulate mode leaves the mask unchanged and still produces an output beat with err_o=1.
- clear_i without an accept: acc <= 0, count_o <= 0, full_o <= 0. bits_o, valid_o and the pending output are untouched.
- clear_i with an accumulate accept in the same cycle: clear takes effect first, then the new word is ORed in (acc = onehot).
- count_o and full_o are registered and track the accumulator value after each update. full_o = (count_o == N_BITS).
- Once full, further words set dup_o=1 and the mask stays all-ones. There is no wrap and no auto-clear.
- mode_i may change beat-to-beat. A decode beat between accumulate beats does not disturb the accumulator.
- Reset asserted mid-transfer drops any pending beat: valid_o=0 on the next cycle.

Test Plan:
1. Reset with N_BITS=16, then decode words 0, 5, 15 with ready_i=1 -> bits_o = 0x0001, 0x0020, 0x8000, each 1 cycle after accept; count_o stays 0.
2. Accumulate words 3, 7, 3 -> bits_o = 0x0008, 0x0088, 0x0088; dup_o = 0, 0, 1; count_o = 1, 2, 2.
3. Accumulate all 16 words in random order -> final bits_o=0xFFFF, count_o=16, full_o=1. An extra word 9 -> dup_o=1, mask unchanged.
4. Hold ready_i=0 after one beat (word 2, decode) while presenting word 4 -> ready_o=0, bits_o holds 0x0004. Release ready_i -> word 4 is accepted and the next output is 0x0010.
5. Configure N_BITS=10, WORD_W=4 and accumulate word 12 -> err_o=1, bits_o = previous mask, count_o unchanged.
6. Accumulator at 0x00F0; assert clear_i with an accumulate accept of word 1 -> bits_o=0x0002, count_o=1, dup_o=0. Then assert rst_n_i=0 for one cycle with valid_o=1 -> all outputs return to 0 next cycle.
